// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and types for the 640x480@60 text-mode timing block.
//   - horizontal / vertical visible, porch, sync and total lengths
//   - glyph size (8x16), character grid (80x30), text-address width
//   - pipeline latency from counter state to outputs
//   - pix_sb_t: per-pixel sideband carried down the alignment pipeline
package vga_pkg;

    // Horizontal timing, in pixel clocks
    localparam int unsigned HVisible = 640;
    localparam int unsigned HFront   = 16;
    localparam int unsigned HSync    = 96;
    localparam int unsigned HBack    = 48;
    localparam int unsigned HTotal   = HVisible + HFront + HSync + HBack;  // 800

    // Vertical timing, in lines
    localparam int unsigned VVisible = 480;
    localparam int unsigned VFront   = 10;
    localparam int unsigned VSync    = 2;
    localparam int unsigned VBack    = 33;
    localparam int unsigned VTotal   = VVisible + VFront + VSync + VBack;  // 525

    // Glyph and character grid
    localparam int unsigned GlyphW   = 8;
    localparam int unsigned GlyphH   = 16;
    localparam int unsigned GridCols = 80;
    localparam int unsigned GridRows = 30;

    localparam int unsigned AddrW       = 12;
    localparam int unsigned CharW       = 8;
    localparam int unsigned PipeLatency = 3;

    localparam int unsigned CntW = 10;
    localparam int unsigned ColW = $clog2(GlyphW);  // columna width
    localparam int unsigned RowW = $clog2(GlyphH);  // fila width

    // Counter-width decode points
    localparam logic [CntW-1:0] HLast     = CntW'(HTotal - 1);
    localparam logic [CntW-1:0] HVisEnd   = CntW'(HVisible);
    localparam logic [CntW-1:0] HSyncBeg  = CntW'(HVisible + HFront);
    localparam logic [CntW-1:0] HSyncEnd  = CntW'(HVisible + HFront + HSync);
    localparam logic [CntW-1:0] VLast     = CntW'(VTotal - 1);
    localparam logic [CntW-1:0] VVisEnd   = CntW'(VVisible);
    localparam logic [CntW-1:0] VSyncBeg  = CntW'(VVisible + VFront);
    localparam logic [CntW-1:0] VSyncEnd  = CntW'(VVisible + VFront + VSync);

    localparam logic [RowW-1:0]      GlyphLastRow = RowW'(GlyphH - 1);
    localparam logic [CntW-RowW-1:0] LastCellRow  = (CntW-RowW)'(GridRows - 1);
    localparam logic [AddrW-1:0]     RowStep      = AddrW'(GridCols);

    typedef struct packed {
        logic            hsync;
        logic            vsync;
        logic            blank;
        logic            frame_start;
        logic [ColW-1:0] columna;
        logic [RowW-1:0] fila;
    } pix_sb_t;

    // Idle value of the sideband: syncs inactive, blanked
    localparam pix_sb_t SbIdle = '{
        hsync:       1'b1,
        vsync:       1'b1,
        blank:       1'b1,
        frame_start: 1'b0,
        columna:     '0,
        fila:        '0
    };

endpackage

// File: rtl/vga_sync_counter.sv
// vga_sync_counter: horizontal/vertical pixel counters plus sync/blank decode.
//   clk_i          pixel clock
//   rst_ni         asynchronous active-low reset, counters clear to (0,0)
//   h_cnt_o        horizontal position 0..799
//   v_cnt_o        vertical position 0..524
//   line_end_o     h_cnt_o is on the last pixel of the line
//   hsync_o        active-low horizontal sync, decoded from the current counters
//   vsync_o        active-low vertical sync, decoded from the current counters
//   blank_o        1 outside the 640x480 visible area
//   frame_start_o  1 while the counters sit at (0,0)
module vga_sync_counter
    import vga_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    output logic [CntW-1:0] h_cnt_o,
    output logic [CntW-1:0] v_cnt_o,
    output logic            line_end_o,
    output logic            hsync_o,
    output logic            vsync_o,
    output logic            blank_o,
    output logic            frame_start_o
);

    logic [CntW-1:0] h_q, h_d;
    logic [CntW-1:0] v_q, v_d;
    logic            line_end;

    always_comb begin
        line_end = (h_q == HLast);
        h_d      = line_end ? '0 : h_q + CntW'(1);
        v_d      = v_q;
        if (line_end) begin
            v_d = (v_q == VLast) ? '0 : v_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    always_comb begin
        h_cnt_o       = h_q;
        v_cnt_o       = v_q;
        line_end_o    = line_end;
        hsync_o       = !((h_q >= HSyncBeg) && (h_q < HSyncEnd));
        vsync_o       = !((v_q >= VSyncBeg) && (v_q < VSyncEnd));
        blank_o       = (h_q >= HVisEnd) || (v_q >= VVisEnd);
        frame_start_o = (h_q == '0) && (v_q == '0);
    end

endmodule

// File: rtl/vga_text_timing.sv
// vga_text_timing: 80x30 text-mode VGA timing with text-RAM addressing.
//   clk          25 MHz pixel clock
//   rst_n        asynchronous active-low reset
//   text_addr    registered text-RAM address row*80+col, 0 outside the visible area
//   text_data    character code from the synchronous RAM, one clk after text_addr
//   caracter     character code for the current pixel, 0 when blanked
//   columna      pixel column inside the glyph (0..7)
//   fila         pixel row inside the glyph (0..15)
//   VGA_blank    1 outside the visible area
//   hsync/vsync  active-low syncs
//   frame_start  one-clk pulse on pixel (0,0)
// All outputs except text_addr are three clocks behind the counter state and refer to the
// same pixel; text_addr leads them by two clocks to cover the RAM read.
module vga_text_timing
    import vga_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    output logic [AddrW-1:0] text_addr,
    input  logic [CharW-1:0] text_data,
    output logic [CharW-1:0] caracter,
    output logic [ColW-1:0]  columna,
    output logic [RowW-1:0]  fila,
    output logic             VGA_blank,
    output logic             hsync,
    output logic             vsync,
    output logic             frame_start
);

    logic [CntW-1:0] h_cnt, v_cnt;
    logic            line_end;
    logic            dec_hsync, dec_vsync, dec_blank, dec_frame;

    vga_sync_counter u_cnt (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .h_cnt_o       (h_cnt),
        .v_cnt_o       (v_cnt),
        .line_end_o    (line_end),
        .hsync_o       (dec_hsync),
        .vsync_o       (dec_vsync),
        .blank_o       (dec_blank),
        .frame_start_o (dec_frame)
    );

    logic [AddrW-1:0]              row_base_q, row_base_d;
    logic [AddrW-1:0]              addr_q, addr_d;
    logic [CharW-1:0]              char_q, char_d;
    pix_sb_t                       sb_in;
    pix_sb_t [PipeLatency-1:0]     sb_q;

    // row_base_q always equals (v_cnt/16)*80 for the visible lines; it advances at the end
    // of the last glyph line of each cell row and clears when the frame wraps.
    always_comb begin
        row_base_d = row_base_q;
        if (line_end) begin
            if (v_cnt == VLast) begin
                row_base_d = '0;
            end else if ((v_cnt < VVisEnd) && (v_cnt[RowW-1:0] == GlyphLastRow) &&
                         (v_cnt[CntW-1:RowW] != LastCellRow)) begin
                row_base_d = row_base_q + RowStep;
            end
        end
    end

    always_comb begin
        addr_d = dec_blank ? '0 : row_base_q + AddrW'(h_cnt[CntW-1:ColW]);

        sb_in             = SbIdle;
        sb_in.hsync       = dec_hsync;
        sb_in.vsync       = dec_vsync;
        sb_in.blank       = dec_blank;
        sb_in.frame_start = dec_frame;
        sb_in.columna     = h_cnt[ColW-1:0];
        sb_in.fila        = v_cnt[RowW-1:0];

        // text_data belongs to the pixel now in the second-to-last sideband stage
        char_d = sb_q[PipeLatency-2].blank ? '0 : text_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_base_q <= '0;
            addr_q     <= '0;
            char_q     <= '0;
            sb_q       <= {PipeLatency{SbIdle}};
        end else begin
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
            char_q     <= char_d;
            sb_q       <= {sb_q[PipeLatency-2:0], sb_in};
        end
    end

    always_comb begin
        text_addr   = addr_q;
        caracter    = char_q;
        columna     = sb_q[PipeLatency-1].columna;
        fila        = sb_q[PipeLatency-1].fila;
        VGA_blank   = sb_q[PipeLatency-1].blank;
        hsync       = sb_q[PipeLatency-1].hsync;
        vsync       = sb_q[PipeLatency-1].vsync;
        frame_start = sb_q[PipeLatency-1].frame_start;
    end

endmodule

// File: tb/tb_vga_text_timing.sv
// tb_vga_text_timing: directed bench for vga_text_timing.
// n counts rising edges since the last reset release. Outputs sampled 1 time unit after
// edge n describe virtual pixel index n-3+off (index = v*800+h across frames); off grows when
// the vertical counter is jumped ahead to keep the run short.
module tb_vga_text_timing;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] text_addr;
    logic [7:0]  text_data = 8'd0;
    logic [7:0]  caracter;
    logic [2:0]  columna;
    logic [3:0]  fila;
    logic        VGA_blank, hsync, vsync, frame_start;

    vga_text_timing u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .text_addr   (text_addr),
        .text_data   (text_data),
        .caracter    (caracter),
        .columna     (columna),
        .fila        (fila),
        .VGA_blank   (VGA_blank),
        .hsync       (hsync),
        .vsync       (vsync),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Synchronous RAM model: data = addr[7:0], except address 0 reads 0xA5 so that the
    // blanking of caracter is visible (blank pixels present address 0).
    always @(posedge clk) text_data <= (text_addr == 12'd0) ? 8'hA5 : text_addr[7:0];

    int tests = 0;
    int fails = 0;
    int n     = 0;
    int off   = 0;
    bit mon_en = 1'b0;
    int bad_blank = 0, bad_car = 0, bad_hs = 0, bad_vs = 0, bad_fs = 0;
    int fs_cnt = 0, fs_last = -1, vs_cnt = 0, vs_first = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // One clock; then compare syncs/blank/frame_start against a timing model of the pixel.
    task automatic tick();
        int unsigned vp, h, v;
        logic e_blank, e_hs, e_vs, e_fs;
        @(posedge clk);
        #1;
        n++;
        if (mon_en && n >= 3) begin
            vp      = n - 3 + off;
            h       = vp % 800;
            v       = (vp / 800) % 525;
            e_blank = (h >= 640) || (v >= 480);
            e_hs    = !((h >= 656) && (h <= 751));
            e_vs    = !((v >= 490) && (v <= 491));
            e_fs    = (vp % 420000) == 0;
            if (VGA_blank !== e_blank) bad_blank++;
            if (e_blank && caracter !== 8'd0) bad_car++;
            if (hsync !== e_hs) bad_hs++;
            if (vsync !== e_vs) bad_vs++;
            if (frame_start !== e_fs) bad_fs++;
            if (frame_start === 1'b1) begin
                fs_cnt++;
                fs_last = vp;
            end
            if (vsync === 1'b0) begin
                if (vs_cnt == 0) vs_first = vp;
                vs_cnt++;
            end
        end
    endtask

    task automatic run_to(input int target);
        while (n < target) tick();
    endtask

    task automatic check_reset_outputs(input string pfx);
        chk({pfx, ":rst_hsync"},  hsync,       1);
        chk({pfx, ":rst_vsync"},  vsync,       1);
        chk({pfx, ":rst_blank"},  VGA_blank,   1);
        chk({pfx, ":rst_car"},    caracter,    0);
        chk({pfx, ":rst_col"},    columna,     0);
        chk({pfx, ":rst_fila"},   fila,        0);
        chk({pfx, ":rst_addr"},   text_addr,   0);
        chk({pfx, ":rst_fs"},     frame_start, 0);
    endtask

    // Checks from the first clock after release through the second hsync falling edge.
    task automatic startup_checks(input string pfx);
        int t0, guard;
        run_to(1);
        chk({pfx, ":e1_fs"},    frame_start, 0);
        chk({pfx, ":e1_blank"}, VGA_blank,   1);
        chk({pfx, ":e1_hsync"}, hsync,       1);
        run_to(3);
        chk({pfx, ":e3_fs"},    frame_start, 1);
        chk({pfx, ":e3_blank"}, VGA_blank,   0);
        chk({pfx, ":e3_car"},   caracter,    8'hA5);
        chk({pfx, ":e3_col"},   columna,     0);
        chk({pfx, ":e3_fila"},  fila,        0);
        chk({pfx, ":e3_vsync"}, vsync,       1);
        run_to(4);
        chk({pfx, ":e4_fs"},    frame_start, 0);
        chk({pfx, ":e4_col"},   columna,     1);
        run_to(11);                                   // pixel (8,0)
        chk({pfx, ":p8_car"},   caracter,    1);
        chk({pfx, ":p8_col"},   columna,     0);
        chk({pfx, ":p10_addr"}, text_addr,   1);
        run_to(642);                                  // pixel (639,0)
        chk({pfx, ":p639_car"},   caracter,  8'h4F);
        chk({pfx, ":p639_col"},   columna,   7);
        chk({pfx, ":p639_blank"}, VGA_blank, 0);
        run_to(643);                                  // pixel (640,0)
        chk({pfx, ":p640_blank"}, VGA_blank, 1);
        chk({pfx, ":p640_car"},   caracter,  0);
        chk({pfx, ":p642_addr"},  text_addr, 0);
        guard = 0;
        while (hsync !== 1'b0 && guard < 2000) begin tick(); guard++; end
        chk({pfx, ":hsync_fall"}, n, 659);
        t0 = n;
        guard = 0;
        while (hsync !== 1'b1 && guard < 200) begin tick(); guard++; end
        chk({pfx, ":hsync_width"}, n - t0, 96);
        guard = 0;
        while (hsync !== 1'b0 && guard < 1000) begin tick(); guard++; end
        chk({pfx, ":hsync_period"}, n - t0, 800);
    endtask

    initial begin
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        startup_checks("por");

        // Row step between glyph row 15 and 16
        run_to(12001);  chk("p0_15_addr", text_addr, 0);
        run_to(12801);  chk("p0_16_addr", text_addr, 80);
        run_to(12802);  chk("p799_15_fila", fila, 15);
                        chk("p799_15_blank", VGA_blank, 1);
        run_to(12803);  chk("p0_16_car", caracter, 8'h50);
                        chk("p0_16_fila", fila, 0);

        // Jump from line 17 (h=100) to line 477, row base of cell row 29
        run_to(13700);
        force u_dut.u_cnt.v_q   = 10'd477;
        force u_dut.row_base_q  = 12'd2320;
        off += (477 - 17) * 800;
        tick();
        release u_dut.u_cnt.v_q;
        release u_dut.row_base_q;

        run_to(15840);  chk("p639_479_addr", text_addr, 2399);
        run_to(15842);  chk("p639_479_fila", fila, 15);
                        chk("p639_479_col", columna, 7);
                        chk("p639_479_car", caracter, 8'h5F);
                        chk("p639_479_blank", VGA_blank, 0);
        run_to(16003);  chk("p0_480_blank", VGA_blank, 1);
                        chk("p0_480_car", caracter, 0);

        // Next frame: row base back at 0
        run_to(52001);  chk("f1_p0_addr", text_addr, 0);
        run_to(52003);  chk("f1_fs", frame_start, 1);
        run_to(52011);  chk("f1_p8_car", caracter, 1);
        run_to(52017);  chk("f1_p16_addr", text_addr, 2);
        chk("vsync_start_pixel", vs_first, 490 * 800);
        chk("vsync_low_clks", vs_cnt, 1600);
        chk("fs_pulses", fs_cnt, 2);
        chk("frame_period", fs_last, 420000);

        // Jump to line 200 of frame 1, then reset at (300,200)
        run_to(52020);
        force u_dut.u_cnt.v_q  = 10'd200;
        force u_dut.row_base_q = 12'd960;
        off += 200 * 800;
        tick();
        release u_dut.u_cnt.v_q;
        release u_dut.row_base_q;
        run_to(52300);
        chk("pre_rst_blank", VGA_blank, 0);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check_reset_outputs("mid");
        repeat (5) @(posedge clk);
        #1;
        chk("mid_hold_hsync", hsync, 1);
        chk("mid_hold_fs", frame_start, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        n      = 0;
        off    = 0;
        mon_en = 1'b1;
        startup_checks("mid");

        chk("mon_blank", bad_blank, 0);
        chk("mon_car_blanked", bad_car, 0);
        chk("mon_hsync", bad_hs, 0);
        chk("mon_vsync", bad_vs, 0);
        chk("mon_frame_start", bad_fs, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vga_text_timing.md
VGA_TEXT_TIMING -- requirements
Module: vga_text_timing

Interface
REQ-001 SHALL have port clk, input, 1 bit: 25 MHz pixel clock; the block has one clock, all logic on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-003 SHALL have port text_addr, output, 12 bits: text-buffer read address, row*80+col, range 0..2399.
REQ-004 SHALL have port text_data, input, 8 bits: character code returned by the synchronous text RAM one clk after text_addr.
REQ-005 SHALL have port caracter, output, 8 bits: character code for the current pixel.
REQ-006 SHALL have port columna, output, 3 bits: pixel column inside the 8-wide glyph.
REQ-007 SHALL have port fila, output, 4 bits: pixel row inside the 16-high glyph.
REQ-008 SHALL have port VGA_blank, output, 1 bit: 1 outside the 640x480 visible area.
REQ-009 SHALL have ports hsync and vsync, outputs, 1 bit each: active-low syncs.
REQ-010 SHALL have port frame_start, output, 1 bit: one-cycle pulse aligned to pixel (0,0).

Function
REQ-011 SHALL keep h_cnt 0..799, wrapping 799->0 and then incrementing v_cnt; v_cnt SHALL run 0..524, wrapping 524->0.
REQ-012 Horizontal timing SHALL be visible 0..639, front porch 640..655, sync 656..751 (hsync=0), back porch 752..799.
REQ-013 Vertical timing SHALL be visible 0..479, front porch 480..489, sync 490..491 (vsync=0), back porch 492..524.
REQ-014 VGA_blank SHALL be 1 when h_cnt>=640 or v_cnt>=480.
REQ-015 The character cell SHALL be col=h_cnt[9:3] (0..79) and row=v_cnt[8:4] (0..29); columna=h_cnt[2:0] and fila=v_cnt[3:0].
REQ-016 text_addr SHALL be computed without a multiplier: a row base register adds 80 when v_cnt[3:0] wraps 15->0 inside the visible area, and returns to 0 at v_cnt wrap.
REQ-017 text_addr SHALL be registered, valid 1 clk after counter state (h,v); outside the visible area it SHALL be 0.
REQ-018 caracter SHALL register text_data; the total latency from counter state (h,v) to all outputs SHALL be 3 clk.
REQ-019 hsync, vsync, VGA_blank, columna, fila and frame_start SHALL pass through a matching delay so that every output refers to the same pixel in the same cycle.
REQ-020 caracter SHALL be 0 whenever the aligned VGA_blank is 1.
REQ-021 frame_start SHALL pulse for exactly one clk per 420000-clk frame.

Reset
REQ-022 On rst_n=0, h_cnt, v_cnt, the row base and all pipeline registers SHALL clear immediately.
REQ-023 During reset the outputs SHALL be: hsync=1, vsync=1, VGA_blank=1, caracter=0, columna=0, fila=0, text_addr=0, frame_start=0.
REQ-024 On the first clk after release, the counters SHALL hold (0,0); frame_start SHALL rise 3 clk later.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no partial sync pulse after release.

Structure
REQ-026 Package vga_pkg SHALL hold the H/V visible, porch, sync and total constants, the glyph size (8x16), the grid size (80x30), the text-address width and the pipeline latency constant.
REQ-027 A single sub-module, vga_sync_counter, SHALL hold the h/v counters and the sync/blank decode; the address and alignment pipeline SHALL be in vga_text_timing.

Verification
REQ-028 Reset test: release rst_n -> frame_start=1 at clk 3; the first hsync falling edge at clk 659; hsync low for 96 clk; hsync period 800 clk.
REQ-029 Vertical test: run one frame -> vsync low for exactly 1600 clk, starting 490*800+3 clk after frame_start-3; frame period 420000 clk.
REQ-030 Address test: RAM model returns data=addr[7:0] -> at pixel (8,0) caracter=1 and columna=0; at pixel (639,479) text_addr=2399 and fila=15, columna=7.
REQ-031 Row-step test: at pixel (0,16) text_addr=80; at (0,15) text_addr=0; the row base returns to 0 on the next frame.
REQ-032 Blank test: non-zero text_data during porches -> caracter=0 and VGA_blank=1 for h in 640..799 and for all of lines 480..524.
REQ-033 Mid-frame reset test: assert rst_n=0 at v=200, h=300 for 5 clk -> outputs are at reset values immediately; after release the timing restarts from (0,0) and REQ-028 holds.
